fruit_tally: RTL and testbench

//  Parametrised, sequential successor to the 4-slot fixed judge. Takes a frame-end snapshot of N per-object

---
 rtl/fruit_tally_if.sv | 28 ++
 rtl/fruit_tally.sv | 229 ++++++++++++++++++++++
 tb/tb_fruit_tally.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/fruit_tally_if.sv
// Frame-level handshake and result bus between the recogniser-side driver
// and the fruit_tally reducer. The driver uses the master modport and the
// reducer uses the slave modport.
interface fruit_tally_if #(
  parameter int N = 4,
  parameter int W = 4,
  parameter int K = 3
);
  logic           start;
  logic           sort_mode;
  logic [N*W-1:0] sort_bus;
  logic           busy;
  logic           done;
  logic           overflow;
  logic [3:0]     n_classes;
  logic [K*8-1:0] number_bus;
  logic [K*W-1:0] ca_bus;

  modport master (
    output start, sort_mode, sort_bus,
    input  busy, done, overflow, n_classes, number_bus, ca_bus
  );

  modport slave (
    input  start, sort_mode, sort_bus,
    output busy, done, overflow, n_classes, number_bus, ca_bus
  );
endinterface

// File: rtl/fruit_tally.sv
// fruit_tally: reduces a frame-end snapshot of N class codes to up to K
// distinct (count, class) entries. Slots are scanned one per cycle, the
// table is optionally bubble-sorted by descending count (stable), and the
// result is published in one EMIT cycle as ASCII digits plus class codes.
module fruit_tally #(
  parameter int N = 4,
  parameter int W = 4,
  parameter int K = 3
) (
  input  logic         pixelclk,
  input  logic         rstin,
  fruit_tally_if.slave tally
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int JW = (K > 2) ? $clog2(K - 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    SORT = 2'd2,
    EMIT = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            mode_q, mode_d;
  logic [W-1:0]    slot_q [N];
  logic [W-1:0]    slot_d [N];

  // Working table: class code and count per entry, fill = entries used.
  logic [W-1:0]    code_q [K];
  logic [W-1:0]    code_d [K];
  logic [3:0]      cnt_q  [K];
  logic [3:0]      cnt_d  [K];
  logic [3:0]      fill_q, fill_d;
  logic            fovf_q, fovf_d;

  // Sort sequencing: pass and compare position, each 0..K-2.
  logic [JW-1:0]   pass_q, pass_d;
  logic [JW-1:0]   j_q, j_d;

  // Registered outputs.
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ovf_q, ovf_d;
  logic [3:0]      ncls_q, ncls_d;
  logic [7:0]      num_q [K];
  logic [7:0]      num_d [K];
  logic [W-1:0]    ca_q  [K];
  logic [W-1:0]    ca_d  [K];

  // Scan helpers.
  logic [W-1:0]    cur;
  logic            hit;

  // Next-state and datapath for the IDLE/SCAN/SORT/EMIT sequencer.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d = state_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    slot_d  = slot_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    fovf_d  = fovf_q;
    pass_d  = pass_q;
    j_d     = j_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    ncls_d  = ncls_q;
    num_d   = num_q;
    ca_d    = ca_q;
    cur     = '0;
    hit     = 1'b0;

    case (state_q)
      IDLE: begin
        if (tally.start) begin
          for (int i = 0; i < N; i++) begin
            slot_d[i] = tally.sort_bus[i*W +: W];
          end
          for (int k = 0; k < K; k++) begin
            code_d[k] = '0;
            cnt_d[k]  = '0;
          end
          mode_d  = tally.sort_mode;
          fill_d  = '0;
          fovf_d  = 1'b0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = SCAN;
        end
      end

      SCAN: begin
        for (int i = 0; i < N; i++) begin
          if (idx_q == IW'(i)) cur = slot_q[i];
        end
        // Code 0 means no object in this slot; otherwise count or append.
        if (cur != '0) begin
          for (int k = 0; k < K; k++) begin
            if (!hit && (4'(k) < fill_q) && (code_q[k] == cur)) begin
              cnt_d[k] = cnt_q[k] + 4'd1;
              hit      = 1'b1;
            end
          end
          if (!hit) begin
            if (fill_q < 4'(K)) begin
              for (int k = 0; k < K; k++) begin
                if (4'(k) == fill_q) begin
                  code_d[k] = cur;
                  cnt_d[k]  = 4'd1;
                end
              end
              fill_d = fill_q + 4'd1;
            end else begin
              fovf_d = 1'b1;
            end
          end
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(N - 1)) begin
          idx_d   = '0;
          pass_d  = '0;
          j_d     = '0;
          state_d = (mode_q && (K > 1)) ? SORT : EMIT;
        end
      end

      SORT: begin
        // Strictly-greater swap keeps ties in first-appearance order.
        for (int j = 0; j < K - 1; j++) begin
          if ((j_q == JW'(j)) && (cnt_q[j+1] > cnt_q[j])) begin
            code_d[j]   = code_q[j+1];
            code_d[j+1] = code_q[j];
            cnt_d[j]    = cnt_q[j+1];
            cnt_d[j+1]  = cnt_q[j];
          end
        end
        if (j_q == JW'(K - 2)) begin
          j_d    = '0;
          pass_d = pass_q + 1'b1;
          if (pass_q == JW'(K - 2)) state_d = EMIT;
        end else begin
          j_d = j_q + 1'b1;
        end
      end

      EMIT: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
        // An empty frame leaves the previously published result in place.
        if (fill_q != '0) begin
          for (int j = 0; j < K; j++) begin
            if (4'(j) < fill_q) begin
              num_d[j] = 8'h30 + {4'h0, cnt_q[j]};
              ca_d[j]  = code_q[j];
            end else begin
              num_d[j] = 8'h20;
              ca_d[j]  = '0;
            end
          end
          ncls_d = fill_q;
          ovf_d  = fovf_q;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, table and output registers; reset aborts any frame in flight.
  always_ff @(posedge pixelclk or negedge rstin) begin
    if (!rstin) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mode_q  <= 1'b0;
      fill_q  <= '0;
      fovf_q  <= 1'b0;
      pass_q  <= '0;
      j_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ncls_q  <= '0;
      // NOTE: the small slot/table arrays are plain flops, so they are reset like any other state.
      for (int i = 0; i < N; i++) slot_q[i] <= '0;
      for (int k = 0; k < K; k++) begin
        code_q[k] <= '0;
        cnt_q[k]  <= '0;
        num_q[k]  <= 8'h20;
        ca_q[k]   <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      slot_q  <= slot_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      fovf_q  <= fovf_d;
      pass_q  <= pass_d;
      j_q     <= j_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      ncls_q  <= ncls_d;
      num_q   <= num_d;
      ca_q    <= ca_d;
    end
  end

  assign tally.busy      = busy_q;
  assign tally.done      = done_q;
  assign tally.overflow  = ovf_q;
  assign tally.n_classes = ncls_q;

  for (genvar g = 0; g < K; g++) begin : g_out
    assign tally.number_bus[g*8 +: 8] = num_q[g];
    assign tally.ca_bus[g*W +: W]     = ca_q[g];
  end

endmodule

// File: tb/tb_fruit_tally.sv
// Directed bench for fruit_tally: a table of frames on the default
// (N=4, W=4, K=3) instance, plus hand sequences for back-to-back frames,
// reset mid-scan, and a start pulse while busy on an N=9, K=4 instance.
module tb_fruit_tally;

  logic pixelclk = 1'b0;
  logic rstin;

  always #5 pixelclk = ~pixelclk;

  fruit_tally_if #(.N(4), .W(4), .K(3)) if0 ();
  fruit_tally_if #(.N(9), .W(4), .K(4)) if1 ();

  fruit_tally #(.N(4), .W(4), .K(3)) u_dut0 (
    .pixelclk (pixelclk),
    .rstin    (rstin),
    .tally    (if0)
  );

  fruit_tally #(.N(9), .W(4), .K(4)) u_dut1 (
    .pixelclk (pixelclk),
    .rstin    (rstin),
    .tally    (if1)
  );

  typedef struct {
    logic        mode;
    logic [15:0] slots;   // slot0 in bits [3:0]
    logic [23:0] num;     // entry0 in bits [7:0]
    logic [11:0] ca;      // entry0 in bits [3:0]
    logic [3:0]  ncls;
    logic        ovf;
    int          lat;     // edges from accepting edge to done
  } vec_t;

  vec_t vecs [10];

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Present a frame on DUT0 and hold start through one edge; then scramble
  // the bus to show that only the captured snapshot matters.
  task automatic launch(input logic m, input logic [15:0] s);
    if0.start     = 1'b1;
    if0.sort_mode = m;
    if0.sort_bus  = s;
    @(posedge pixelclk);
    #1;
    if0.start     = 1'b0;
    if0.sort_mode = ~m;
    if0.sort_bus  = ~s;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge pixelclk);
      #1;
      if (if0.done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic check_out(input string tag, input vec_t v);
    check({tag, "_num"},  64'(if0.number_bus), 64'(v.num));
    check({tag, "_ca"},   64'(if0.ca_bus),     64'(v.ca));
    check({tag, "_ncls"}, 64'(if0.n_classes),  64'(v.ncls));
    check({tag, "_ovf"},  64'(if0.overflow),   64'(v.ovf));
  endtask

  task automatic apply(input string tag, input vec_t v);
    int lat;
    @(negedge pixelclk);
    launch(v.mode, v.slots);
    check({tag, "_busy_hi"}, 64'(if0.busy), 64'd1);
    wait_done(lat);
    check({tag, "_lat"}, 64'(lat), 64'(v.lat));
    check_out(tag, v);
    check({tag, "_busy_lo"}, 64'(if0.busy), 64'd0);
    @(posedge pixelclk);
    #1;
    check({tag, "_done_pulse"}, 64'(if0.done), 64'd0);
  endtask

  initial begin
    int   lat;
    int   ndone;
    vec_t v;

    vecs[0] = '{1'b0, 16'h1111, 24'h202034, 12'h001, 4'd1, 1'b0, 5};
    vecs[1] = '{1'b0, 16'h0552, 24'h203231, 12'h052, 4'd2, 1'b0, 5};
    vecs[2] = '{1'b1, 16'h0552, 24'h203132, 12'h025, 4'd2, 1'b0, 9};
    vecs[3] = '{1'b0, 16'h3030, 24'h202032, 12'h003, 4'd1, 1'b0, 5};
    vecs[4] = '{1'b0, 16'h4321, 24'h313131, 12'h321, 4'd3, 1'b1, 5};
    vecs[5] = '{1'b0, 16'h0000, 24'h313131, 12'h321, 4'd3, 1'b1, 5};
    vecs[6] = '{1'b1, 16'h0000, 24'h313131, 12'h321, 4'd3, 1'b1, 9};
    vecs[7] = '{1'b1, 16'h4414, 24'h203133, 12'h014, 4'd2, 1'b0, 9};
    vecs[8] = '{1'b1, 16'h6996, 24'h203232, 12'h096, 4'd2, 1'b0, 9};
    vecs[9] = '{1'b1, 16'h3321, 24'h313132, 12'h213, 4'd3, 1'b0, 9};

    rstin         = 1'b0;
    if0.start     = 1'b0;
    if0.sort_mode = 1'b0;
    if0.sort_bus  = '0;
    if1.start     = 1'b0;
    if1.sort_mode = 1'b0;
    if1.sort_bus  = '0;

    // Reset state.
    @(negedge pixelclk);
    @(negedge pixelclk);
    check("rst_busy", 64'(if0.busy),       64'd0);
    check("rst_done", 64'(if0.done),       64'd0);
    check("rst_ovf",  64'(if0.overflow),   64'd0);
    check("rst_ncls", 64'(if0.n_classes),  64'd0);
    check("rst_num",  64'(if0.number_bus), 64'h202020);
    check("rst_ca",   64'(if0.ca_bus),     64'h000);
    check("rst_num1", 64'(if1.number_bus), 64'h20202020);
    rstin = 1'b1;

    // Table of frames.
    for (int i = 0; i < 10; i++) begin
      apply($sformatf("v%0d", i), vecs[i]);
    end

    // Start coincident with done is accepted as a new frame.
    @(negedge pixelclk);
    launch(1'b0, 16'h1111);
    wait_done(lat);
    check("b2b_lat0", 64'(lat), 64'd5);
    launch(1'b1, 16'h0552);
    check("b2b_busy", 64'(if0.busy), 64'd1);
    wait_done(lat);
    check("b2b_lat1", 64'(lat), 64'd9);
    check_out("b2b", vecs[2]);

    // Reset asserted during SCAN: immediate clear, no done.
    @(negedge pixelclk);
    launch(1'b0, 16'h7177);
    @(posedge pixelclk);
    @(posedge pixelclk);
    #1 rstin = 1'b0;
    #1;
    check("mrst_busy", 64'(if0.busy),       64'd0);
    check("mrst_done", 64'(if0.done),       64'd0);
    check("mrst_num",  64'(if0.number_bus), 64'h202020);
    check("mrst_ca",   64'(if0.ca_bus),     64'h000);
    check("mrst_ncls", 64'(if0.n_classes),  64'd0);
    @(negedge pixelclk);
    rstin = 1'b1;
    ndone = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge pixelclk);
      #1;
      if (if0.done) ndone++;
    end
    check("mrst_no_done", 64'(ndone), 64'd0);
    v = '{1'b0, 16'h7177, 24'h203133, 12'h017, 4'd2, 1'b0, 5};
    apply("post_rst", v);

    // N=9, K=4, descending sort, with a second start while busy.
    @(negedge pixelclk);
    if1.start     = 1'b1;
    if1.sort_mode = 1'b1;
    if1.sort_bus  = 36'h444333221;
    @(posedge pixelclk);
    #1;
    if1.start     = 1'b0;
    check("k4_busy", 64'(if1.busy), 64'd1);
    lat   = -1;
    ndone = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 3) begin
        if1.start    = 1'b1;
        if1.sort_bus = 36'h111111111;
      end
      if (c == 4) if1.start = 1'b0;
      @(posedge pixelclk);
      #1;
      if (if1.done) begin
        ndone++;
        if (lat < 0) lat = c;
      end
    end
    check("k4_lat",   64'(lat),            64'd19);
    check("k4_ndone", 64'(ndone),          64'd1);
    check("k4_num",   64'(if1.number_bus), 64'h31323333);
    check("k4_ca",    64'(if1.ca_bus),     64'h1243);
    check("k4_ncls",  64'(if1.n_classes),  64'd4);
    check("k4_ovf",   64'(if1.overflow),   64'd0);
    check("k4_idle",  64'(if1.busy),       64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
